// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Three-state fetch/execute sequencer that owns the PC and fetches
//            instructions. Redirect priority is jr > jump > branch > pc+4.
//            Optional macro PC_EXCEPTION_EN adds exc_req/epc and vectors
//            misaligned jr to EXC_VECTOR.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_addr,
`ifdef PC_EXCEPTION_EN
    input  logic        exc_req,
    output logic [31:0] epc,
`endif
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_imem_req;
    logic        r_instr_valid;
    logic        r_misalign_err;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_jr_misaligned;

    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_jr_misaligned = jr && (jr_addr[1:0] != 2'b00);

    // jr target is always word-aligned; misalignment is reported separately
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jr)
            w_next_pc = {jr_addr[31:2], 2'b00};
        else if (jump)
            w_next_pc = {w_pc_plus4[31:28], jump_target, 2'b00};
        else if (br_taken)
            w_next_pc = w_pc_plus4 + (br_offset << 2);
    end

`ifdef PC_EXCEPTION_EN
    logic [31:0] r_epc;
    assign epc = r_epc;
`else
    logic w_unused_exc;
    assign w_unused_exc = &{1'b0, EXC_VECTOR};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_pc           <= RESET_PC;
            r_instr        <= 32'd0;
            r_imem_req     <= 1'b0;
            r_instr_valid  <= 1'b0;
            r_misalign_err <= 1'b0;
`ifdef PC_EXCEPTION_EN
            r_epc          <= 32'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        r_instr       <= imem_rdata;
                        r_state       <= S_EXEC;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        r_state       <= S_FETCH;
                        r_imem_req    <= 1'b1;
                        r_instr_valid <= 1'b0;
`ifdef PC_EXCEPTION_EN
                        if (exc_req || w_jr_misaligned) begin
                            r_epc <= r_pc;
                            r_pc  <= EXC_VECTOR;
                        end else begin
                            r_pc  <= w_next_pc;
                        end
`else
                        r_pc <= w_next_pc;
`endif
                        if (w_jr_misaligned)
                            r_misalign_err <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req     = r_imem_req;
    assign imem_addr    = r_pc;
    assign pc           = r_pc;
    assign instr        = r_instr;
    assign instr_valid  = r_instr_valid;
    assign misalign_err = r_misalign_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Scoreboard bench for pc_sequencer; expected fetch addresses are
//            queued when a redirect is driven and popped at each fetch request.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [31:0] C_RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] C_EXC_VECTOR = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        jr;
    logic [31:0] jr_addr;
    logic        misalign_err;
`ifdef PC_EXCEPTION_EN
    logic        exc_req;
    logic [31:0] epc;
`endif

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_PC   (C_RESET_PC),
        .EXC_VECTOR (C_EXC_VECTOR)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .pc           (pc),
        .stall        (stall),
        .br_taken     (br_taken),
        .br_offset    (br_offset),
        .jump         (jump),
        .jump_target  (jump_target),
        .jr           (jr),
        .jr_addr      (jr_addr),
`ifdef PC_EXCEPTION_EN
        .exc_req      (exc_req),
        .epc          (epc),
`endif
        .misalign_err (misalign_err)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_mis;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    task automatic clear_redirects();
        stall       = 1'b0;
        br_taken    = 1'b0;
        br_offset   = 32'd0;
        jump        = 1'b0;
        jump_target = 26'd0;
        jr          = 1'b0;
        jr_addr     = 32'd0;
`ifdef PC_EXCEPTION_EN
        exc_req     = 1'b0;
`endif
    endtask

    // Wait (bounded) for a fetch request and compare against the scoreboard
    task automatic wait_req(input string tag);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val($sformatf("%s_req", tag), {31'd0, imem_req}, 32'd1);
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s_sb: got empty scoreboard expected one entry", tag);
        end else begin
            m_pc = exp_q.pop_front();
            check_val($sformatf("%s_addr", tag), imem_addr, m_pc);
            check_val($sformatf("%s_pc", tag), pc, m_pc);
            check_val($sformatf("%s_ival", tag), {31'd0, instr_valid}, 32'd0);
        end
    endtask

    // Return the word; redirects are asserted meanwhile and must be ignored
    task automatic deliver(input string tag, input logic [31:0] word);
        imem_ready  = 1'b1;
        imem_rdata  = word;
        br_taken    = 1'b1;
        br_offset   = 32'h0000_0010;
        jump        = 1'b1;
        jump_target = 26'h3FF_FFFF;
        jr          = 1'b1;
        jr_addr     = 32'h1234_5679;
        @(negedge clk);
        imem_ready = 1'b0;
        clear_redirects();
        m_instr = word;
        check_val($sformatf("%s_valid", tag), {31'd0, instr_valid}, 32'd1);
        check_val($sformatf("%s_instr", tag), instr, word);
        check_val($sformatf("%s_ereq", tag), {31'd0, imem_req}, 32'd0);
        check_val($sformatf("%s_epc", tag), pc, m_pc);
        check_val($sformatf("%s_mis", tag), {31'd0, misalign_err}, {31'd0, m_mis});
    endtask

    task automatic exec(input string tag, input int nstall,
                        input logic b, input logic [31:0] off,
                        input logic j, input logic [25:0] tgt,
                        input logic r, input logic [31:0] ra,
                        input logic [31:0] nxt);
        br_taken = b; br_offset = off; jump = j; jump_target = tgt; jr = r; jr_addr = ra;
        for (int i = 0; i < nstall; i++) begin
            stall = 1'b1;
            @(negedge clk);
            check_val($sformatf("%s_hpc%0d", tag, i), pc, m_pc);
            check_val($sformatf("%s_hin%0d", tag, i), instr, m_instr);
            check_val($sformatf("%s_hrq%0d", tag, i), {31'd0, imem_req}, 32'd0);
            check_val($sformatf("%s_hiv%0d", tag, i), {31'd0, instr_valid}, 32'd1);
        end
        stall = 1'b0;
        exp_q.push_back(nxt);
        @(negedge clk);
        clear_redirects();
        check_val($sformatf("%s_adv", tag), {31'd0, imem_req}, 32'd1);
    endtask

    task automatic seq(input string tag, input logic [31:0] word);
        exec(tag, 0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, m_pc + 32'd4);
        wait_req(tag);
        deliver(tag, word);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
        m_mis      = 1'b0;
        m_pc       = C_RESET_PC;
        m_instr    = 32'd0;
        clear_redirects();
        repeat (2) @(negedge clk);

        check_val("rst_pc", pc, C_RESET_PC);
        check_val("rst_req", {31'd0, imem_req}, 32'd0);
        check_val("rst_ival", {31'd0, instr_valid}, 32'd0);
        check_val("rst_instr", instr, 32'd0);
        check_val("rst_mis", {31'd0, misalign_err}, 32'd0);

        rst_n = 1'b1;
        exp_q.push_back(C_RESET_PC);
        @(negedge clk);
        check_val("rel_req", {31'd0, imem_req}, 32'd1);
        wait_req("f0");
        deliver("f0", 32'hA000_0000);
        seq("s1", 32'hA000_0001);
        seq("s2", 32'hA000_0002);
        seq("s3", 32'hA000_0003);
        seq("s4", 32'hA000_0004);

        exec("br", 0, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'd0, 1'b0, 32'd0, 32'h0040_000C);
        wait_req("br"); deliver("br", 32'hB000_0000);

        exec("bj", 0, 1'b1, 32'hFFFF_FFFE, 1'b1, 26'h010_0040, 1'b0, 32'd0, 32'h0040_0100);
        wait_req("bj"); deliver("bj", 32'hB000_0001);

        exec("all", 0, 1'b1, 32'h0000_0100, 1'b1, 26'h000_0001, 1'b1, 32'hF000_0000, 32'hF000_0000);
        wait_req("all"); deliver("all", 32'hB000_0002);

        exec("jmp", 0, 1'b0, 32'd0, 1'b1, 26'h000_0100, 1'b0, 32'd0, 32'hF000_0400);
        wait_req("jmp"); deliver("jmp", 32'hB000_0003);

        exec("stl", 3, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, 32'hF000_0404);
        wait_req("stl"); deliver("stl", 32'hB000_0004);

        exec("jrt", 0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        wait_req("jrt"); deliver("jrt", 32'hB000_0005);
        seq("wrap", 32'hB000_0006);
        check_val("wrap_pc", pc, 32'h0000_0000);

`ifdef PC_EXCEPTION_EN
        exec("mis", 0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h0040_0006, C_EXC_VECTOR);
        m_mis = 1'b1;
        wait_req("mis"); deliver("mis", 32'hC000_0000);
        check_val("mis_epc", epc, 32'h0000_0000);
        seq("mis2", 32'hC000_0001);
        exc_req = 1'b1;
        exec("exc", 0, 1'b0, 32'd0, 1'b1, 26'h000_0010, 1'b0, 32'd0, C_EXC_VECTOR);
        wait_req("exc"); deliver("exc", 32'hC000_0002);
        check_val("exc_epc", epc, C_EXC_VECTOR + 32'd4);
`else
        exec("mis", 0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h0040_0006, 32'h0040_0004);
        m_mis = 1'b1;
        wait_req("mis"); deliver("mis", 32'hC000_0000);
        seq("mis2", 32'hC000_0001);
        seq("mis3", 32'hC000_0002);
`endif

        // Reset while a fetch is outstanding, with a late ready around release
        exec("pre", 0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, m_pc + 32'd4);
        wait_req("pre");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        m_mis = 1'b0;
        check_val("mr_pc", pc, C_RESET_PC);
        check_val("mr_req", {31'd0, imem_req}, 32'd0);
        check_val("mr_ival", {31'd0, instr_valid}, 32'd0);
        check_val("mr_mis", {31'd0, misalign_err}, 32'd0);
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(C_RESET_PC);
        @(negedge clk);
        check_val("late_instr", instr, 32'd0);
        check_val("late_ival", {31'd0, instr_valid}, 32'd0);
        imem_ready = 1'b0;
        wait_req("rf0");
        deliver("rf0", 32'hE000_0000);
        seq("rf1", 32'hE000_0001);
        check_val("rf1_pc", pc, 32'h0040_0004);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
